// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the sram-like request arbiter: source IDs carried
// through the response-order FIFO and default sizing parameters.
package sram_req_arbiter_pkg;

  // Source ID pushed per accepted request; 1 bit is enough for two ports.
  typedef logic src_t;

  localparam src_t SRC_INST = 1'b0;
  localparam src_t SRC_DATA = 1'b1;

  // Accepted-but-unanswered transactions the downstream bridge may hold (1..4).
  localparam int unsigned DEF_OUTSTANDING  = 2;
  // Back-to-back data grants tolerated while inst is kept waiting.
  localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_req_arbiter_id_order_fifo.sv
// id_order_fifo: remembers which source issued each accepted request so that
// in-order responses can be steered back to the right port.
//
// Ports:
//   aclk, areset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din    : enqueue din (ignored when full)
//   pop          : dequeue the head (ignored when empty)
//   full, empty  : occupancy flags
//   head         : source ID at the read pointer, valid when !empty
module id_order_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned Depth = DEF_OUTSTANDING
) (
  input  logic aclk,
  input  logic areset,
  input  logic push,
  input  src_t din,
  input  logic pop,
  output logic full,
  output logic empty,
  output src_t head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  src_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= SRC_INST;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges the CPU instruction and data sram-like ports onto a
// single sram-like master feeding the AXI bridge. Data has priority; inst is
// forced through after STARVE_LIMIT consecutive data grants while it waits.
// A request stalled by m_addr_ok locks the grant until it is accepted.
// Responses return in order and are routed via a FIFO of source IDs.
//
// Ports:
//   aclk, areset                       : clock, async active-high reset
//   inst_* / data_*                    : upstream sram-like slave ports
//   m_req, m_wr, m_size, m_addr, m_wdata : downstream request
//   m_rdata, m_addr_ok, m_data_ok        : downstream response
//   err_unexpected                     : sticky, response with nothing outstanding
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = DEF_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        aclk,
  input  logic        areset,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // downstream master
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        err_unexpected
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic               lock_q, lock_d;
  src_t               lock_src_q, lock_src_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               err_q, err_d;

  src_t arb_src, sel, fifo_head;
  logic sel_req, accept, pop, fifo_full, fifo_empty;

  // Fresh arbitration; only consulted when no grant is locked.
  always_comb begin
    arb_src = SRC_INST;
    if (data_req && !(inst_req && (starve_q == StarveMax))) arb_src = SRC_DATA;
  end

  assign sel     = lock_q ? lock_src_q : arb_src;
  assign sel_req = (sel == SRC_DATA) ? data_req : inst_req;

  // Full gating ignores a same-cycle pop to keep m_req off the response path.
  assign m_req   = sel_req & ~fifo_full & ~areset;
  assign m_wr    = (sel == SRC_DATA) ? data_wr    : inst_wr;
  assign m_size  = (sel == SRC_DATA) ? data_size  : inst_size;
  assign m_addr  = (sel == SRC_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (sel == SRC_DATA) ? data_wdata : inst_wdata;

  assign accept       = m_req & m_addr_ok;
  assign inst_addr_ok = accept & (sel == SRC_INST);
  assign data_addr_ok = accept & (sel == SRC_DATA);

  assign pop          = m_data_ok & ~fifo_empty & ~areset;
  assign inst_data_ok = pop & (fifo_head == SRC_INST);
  assign data_data_ok = pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign err_unexpected = err_q;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (m_req) begin
      lock_d     = 1'b1;
      lock_src_d = sel;
    end
  end

  // Counts data grants taken while inst waits; any inst grant or idle inst clears.
  always_comb begin
    starve_d = starve_q;
    if (!inst_req) begin
      starve_d = '0;
    end else if (accept) begin
      if (sel == SRC_INST)            starve_d = '0;
      else if (starve_q != StarveMax) starve_d = starve_q + 1'b1;
    end
  end

  assign err_d = err_q | (m_data_ok & fifo_empty);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INST;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  id_order_fifo #(
    .Depth (OUTSTANDING)
  ) u_order_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (accept),
    .din    (sel),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, maximum accepted-but-unanswered transactions (1..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants allowed while inst is waiting.
REQ-003 aclk  input  1  single clock; all state updates on posedge aclk.
REQ-004 areset  input  1  reset, asynchronous and active-high.
REQ-005 inst_req / inst_wr  input  1 each  instruction-port request / write flag.
REQ-006 inst_size  input  2, inst_addr  input  32, inst_wdata  input  32  instruction-port request fields.
REQ-007 inst_rdata  output  32, inst_addr_ok  output  1, inst_data_ok  output  1  instruction-port responses.
REQ-008 data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok  SHALL be identical in direction and width to the inst_* set, for the data port.
REQ-009 m_req, m_wr  output  1 each; m_size  output  2; m_addr, m_wdata  output  32  downstream request to the single sram-like-to-AXI bridge.
REQ-010 m_rdata  input  32, m_addr_ok  input  1, m_data_ok  input  1  downstream responses.
REQ-011 err_unexpected  output  1  sticky flag: m_data_ok arrived with no outstanding transaction.

Function
REQ-012 Arbitration SHALL be evaluated only when no grant is locked; data wins over inst unless starve_cnt == STARVE_LIMIT and inst_req is high, in which case inst wins.
REQ-013 When m_req is asserted and m_addr_ok is low, the grant SHALL lock (lock=1, lock_src registered) and m_* request fields SHALL come from lock_src until m_addr_ok.
REQ-014 m_req SHALL equal the selected requester's req, gated low while the order FIFO holds OUTSTANDING entries, regardless of a same-cycle pop.
REQ-015 m_wr/m_size/m_addr/m_wdata SHALL be muxed combinationally from the selected source; addr_ok SHALL be returned only to that source: src_addr_ok = m_req & m_addr_ok & (sel == src).
REQ-016 On each m_req & m_addr_ok, the source ID (0 = inst, 1 = data) SHALL be pushed into an order FIFO of depth OUTSTANDING and lock SHALL clear.
REQ-017 On m_data_ok with a non-empty FIFO, data_ok SHALL go to the source at the FIFO head in the same cycle and the head SHALL pop; m_rdata SHALL be driven to both inst_rdata and data_rdata.
REQ-018 Same-cycle push and pop SHALL both take effect; count stays unchanged; pointers wrap modulo OUTSTANDING.
REQ-019 m_data_ok with an empty FIFO SHALL be ignored for routing and SHALL set err_unexpected until reset.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on a data grant accepted while inst_req is high, and SHALL clear on an inst grant accepted or when inst_req is low.
REQ-021 A request is accepted only on an m_addr_ok cycle; a lower-priority port SHALL never see addr_ok while the other port holds the grant.

Reset
REQ-022 While areset is high: lock=0, starve_cnt=0, FIFO empty (pointers and count 0), err_unexpected=0; m_req=0, inst_addr_ok=data_addr_ok=0, inst_data_ok=data_data_ok=0.
REQ-023 Reset mid-transaction SHALL discard all outstanding entries; responses arriving after release SHALL be treated per REQ-019.

Structure
REQ-024 Source ID encodings (SRC_INST=0, SRC_DATA=1) and the default OUTSTANDING and STARVE_LIMIT values SHALL live in the shared CPU package.
REQ-025 The order FIFO SHALL be a separate sub-module, id_order_fifo (1-bit payload, parameterized depth, push/pop/full/empty/head).

Verification
REQ-026 Inst read only, addr 0xBFC00000; m_addr_ok=1 at cycle 2, m_data_ok at cycle 5 with rdata 0x3C080001 -> inst_addr_ok at cycle 2, inst_data_ok at cycle 5 with inst_rdata=0x3C080001, no data_* strobes.
REQ-027 Inst and data request in the same cycle (data write to 0x80000010, wdata 0xDEADBEEF, size 2) -> data granted first; m_wr=1, m_addr=0x80000010; inst is accepted on the next m_addr_ok.
REQ-028 Inst held high and data re-requesting continuously, m_addr_ok always 1 -> exactly 4 data grants, then 1 inst grant, then the pattern repeats.
REQ-029 Three back-to-back accepted requests, OUTSTANDING=2, no m_data_ok -> m_req low after the 2nd accept; one m_data_ok re-enables it the following cycle; data_ok order matches accept order.
REQ-030 Data request locked with m_addr_ok low for 3 cycles while inst_req rises -> m_addr stays the data address and inst_addr_ok stays 0 throughout.
REQ-031 m_data_ok with an empty FIFO, then areset asserted mid-transaction -> err_unexpected=1 until reset; all outputs reach REQ-022 values asynchronously.
